// File: rtl/st7789_spi_sink.sv
// ST7789 panel-side receiver: synchronises the 3-wire SCL/SDA/DC stream,
// deserialises it into bytes and decodes CASET/RASET/RAMWR into frame-buffer
// writes. Also tracks display on/off and signals frame completion.
module st7789_spi_sink #(
  parameter int SYNC_STAGES = 2,
  parameter int XMAX        = 239,
  parameter int YMAX        = 239
) (
  input  logic        w_clk,
  input  logic        w_rst,
  input  logic        st7789_SCL,
  input  logic        st7789_SDA,
  input  logic        st7789_DC,
  input  logic        st7789_RES,
  output logic        byte_valid,
  output logic [7:0]  byte_data,
  output logic        byte_dc,
  output logic        pix_we,
  output logic [15:0] pix_addr,
  output logic [15:0] pix_data,
  output logic        disp_on,
  output logic        frame_done
);

  localparam logic [7:0] CMD_SWRESET = 8'h01;
  localparam logic [7:0] CMD_DISPOFF = 8'h28;
  localparam logic [7:0] CMD_DISPON  = 8'h29;
  localparam logic [7:0] CMD_CASET   = 8'h2A;
  localparam logic [7:0] CMD_RASET   = 8'h2B;
  localparam logic [7:0] CMD_RAMWR   = 8'h2C;
  localparam logic [7:0] CMD_MADCTL  = 8'h36;
  localparam logic [7:0] CMD_COLMOD  = 8'h3A;

  localparam logic [7:0] XE_RST = 8'(XMAX);
  localparam logic [7:0] YE_RST = 8'(YMAX);
  localparam logic [8:0] X_LIM  = 9'(XMAX);
  localparam logic [8:0] Y_LIM  = 9'(YMAX);

  typedef enum logic [2:0] {
    S_IDLE, S_P_CA, S_P_RA, S_SKIP1, S_RAM_HI, S_RAM_LO
  } state_t;

  // Deserialiser state: bit counter, partial byte and the registered byte strobe.
  typedef struct packed {
    logic       scl_prev;
    logic [2:0] cnt;
    logic [6:0] shift;
    logic       valid;
    logic [7:0] data;
    logic       dc;
  } des_t;

  localparam des_t DES_RST = '{scl_prev: 1'b1, cnt: 3'd0, shift: 7'd0,
                               valid: 1'b0, data: 8'd0, dc: 1'b0};

  // Decoder state: FSM, address window, write pointer and registered outputs.
  typedef struct packed {
    state_t      st;
    logic [1:0]  pidx;
    logic [7:0]  xs;
    logic [7:0]  xe;
    logic [7:0]  ys;
    logic [7:0]  ye;
    logic [7:0]  x;
    logic [7:0]  y;
    logic [7:0]  hi;
    logic        pix_we;
    logic        frame_done;
    logic [15:0] addr;
    logic [15:0] data;
    logic        disp_on;
  } dec_t;

  localparam dec_t DEC_RST = '{st: S_IDLE, pidx: 2'd0, xs: 8'd0, xe: XE_RST,
                               ys: 8'd0, ye: YE_RST, x: 8'd0, y: 8'd0, hi: 8'd0,
                               pix_we: 1'b0, frame_done: 1'b0, addr: 16'd0,
                               data: 16'd0, disp_on: 1'b0};

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q, dc_sync_q;
  des_t des_q;
  dec_t dec_q;

  logic scl_s, sda_s, dc_s, scl_fall;
  logic in_range, at_end;

  assign scl_s    = scl_sync_q[SYNC_STAGES-1];
  assign sda_s    = sda_sync_q[SYNC_STAGES-1];
  assign dc_s     = dc_sync_q[SYNC_STAGES-1];
  assign scl_fall = des_q.scl_prev & ~scl_s;

  assign in_range = ({1'b0, dec_q.x} <= X_LIM) && ({1'b0, dec_q.y} <= Y_LIM);
  assign at_end   = (dec_q.x == dec_q.xe) && (dec_q.y == dec_q.ye);

  // Synchronise the serial inputs and shift in SDA on each SCL falling edge.
  // NOTE: w_rst clears asynchronously, st7789_RES low clears on the clock edge;
  // both restore the same idle values (SCL idles high so no false edge follows).
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '0;
      dc_sync_q  <= '0;
      des_q      <= DES_RST;
    end else if (!st7789_RES) begin
      scl_sync_q <= '1;
      sda_sync_q <= '0;
      dc_sync_q  <= '0;
      des_q      <= DES_RST;
    end else begin
      // NOTE: non-blocking assignments throughout, so every flop samples the
      // pre-edge value of its neighbour and the chain shifts one stage per clock.
      scl_sync_q[0] <= st7789_SCL;
      sda_sync_q[0] <= st7789_SDA;
      dc_sync_q[0]  <= st7789_DC;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        scl_sync_q[i] <= scl_sync_q[i-1];
        sda_sync_q[i] <= sda_sync_q[i-1];
        dc_sync_q[i]  <= dc_sync_q[i-1];
      end
      des_q.scl_prev <= scl_s;
      des_q.valid    <= 1'b0;
      if (scl_fall) begin
        des_q.shift <= {des_q.shift[5:0], sda_s};
        des_q.cnt   <= des_q.cnt + 3'd1;
        if (des_q.cnt == 3'd7) begin
          des_q.valid <= 1'b1;
          des_q.data  <= {des_q.shift, sda_s};
          des_q.dc    <= dc_s;
        end
      end
    end
  end

  // Command decoder FSM; advances only on a received byte.
  always_ff @(posedge w_clk or posedge w_rst) begin
    if (w_rst) begin
      dec_q <= DEC_RST;
    end else if (!st7789_RES) begin
      dec_q <= DEC_RST;
    end else begin
      dec_q.pix_we     <= 1'b0;
      dec_q.frame_done <= 1'b0;
      if (des_q.valid) begin
        if (!des_q.dc) begin
          // Any command byte aborts the current sequence.
          dec_q.st   <= S_IDLE;
          dec_q.pidx <= 2'd0;
          case (des_q.data)
            CMD_CASET:  dec_q.st <= S_P_CA;
            CMD_RASET:  dec_q.st <= S_P_RA;
            CMD_RAMWR: begin
              dec_q.st <= S_RAM_HI;
              dec_q.x  <= dec_q.xs;
              dec_q.y  <= dec_q.ys;
            end
            CMD_MADCTL, CMD_COLMOD: dec_q.st <= S_SKIP1;
            CMD_DISPON:  dec_q.disp_on <= 1'b1;
            CMD_DISPOFF: dec_q.disp_on <= 1'b0;
            CMD_SWRESET: begin
              dec_q.disp_on <= 1'b0;
              dec_q.xs      <= 8'd0;
              dec_q.xe      <= XE_RST;
              dec_q.ys      <= 8'd0;
              dec_q.ye      <= YE_RST;
            end
            default: ;
          endcase
        end else begin
          case (dec_q.st)
            S_P_CA, S_P_RA: begin
              dec_q.pidx <= dec_q.pidx + 2'd1;
              if (dec_q.pidx == 2'd1) begin
                if (dec_q.st == S_P_CA) dec_q.xs <= des_q.data;
                else                    dec_q.ys <= des_q.data;
              end
              if (dec_q.pidx == 2'd3) begin
                if (dec_q.st == S_P_CA) dec_q.xe <= des_q.data;
                else                    dec_q.ye <= des_q.data;
                dec_q.st <= S_IDLE;
              end
            end
            S_SKIP1: dec_q.st <= S_IDLE;
            S_RAM_HI: begin
              dec_q.hi <= des_q.data;
              dec_q.st <= S_RAM_LO;
            end
            S_RAM_LO: begin
              dec_q.st <= S_RAM_HI;
              if (in_range) begin
                dec_q.pix_we     <= 1'b1;
                dec_q.frame_done <= at_end;
                dec_q.addr       <= {dec_q.y, dec_q.x};
                dec_q.data       <= {dec_q.hi, des_q.data};
              end
              if (dec_q.x == dec_q.xe) begin
                dec_q.x <= dec_q.xs;
                dec_q.y <= (dec_q.y == dec_q.ye) ? dec_q.ys : dec_q.y + 8'd1;
              end else begin
                dec_q.x <= dec_q.x + 8'd1;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign byte_valid = des_q.valid;
  assign byte_data  = des_q.data;
  assign byte_dc    = des_q.dc;
  assign pix_we     = dec_q.pix_we;
  assign pix_addr   = dec_q.addr;
  assign pix_data   = dec_q.data;
  assign disp_on    = dec_q.disp_on;
  assign frame_done = dec_q.frame_done;

endmodule
